// File: rtl/keypad_emulator.sv
// Keypad emulator: queues host key positions and replays them as timed presses on active-low rows.
// row is registered, 1 cycle from col; pushes while full are dropped (sticky overflow) unless a pop coincides.
module keypad_emulator #(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 2_500_000,
  parameter int GAP_CYCLES  = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [3:0] push_key,
  input  logic       start,
  input  logic       clear,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       busy,
  output logic       done,
  output logic       full,
  output logic       empty,
  output logic       overflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, PRESS, GAP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      cur_key_q, cur_key_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            overflow_q, overflow_d;
  logic [3:0]      row_q, row_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pop, push_ok;
  logic [3:0]      mem_q [DEPTH];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_key_d  = cur_key_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    pop        = 1'b0;

    case (state_q)
      IDLE: if (start && !empty_q) state_d = LOAD;
      LOAD: begin
        pop       = !empty_q;
        cur_key_d = mem_q[rd_ptr_q];
        cnt_d     = '0;
        state_d   = PRESS;
      end
      PRESS: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (!empty_q) begin
            state_d = LOAD;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    push_ok = push && (!full_q || pop);
    if (push && full_q && !pop) overflow_d = 1'b1;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;

    if (clear) begin
      state_d  = IDLE;
      cnt_d    = '0;
      done_d   = 1'b0;
      pop      = 1'b0;
      push_ok  = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
    busy_d  = (state_d != IDLE);

    // Look at next state so the press window lines up exactly with PRESS.
    row_d = 4'hF;
    if (state_d == PRESS && !col[cur_key_d[3:2]]) row_d = ~(4'b0001 << cur_key_d[1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cur_key_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      row_q      <= 4'hF;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_key_q  <= cur_key_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      row_q      <= row_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_key;
  end

  assign row      = row_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator with HOLD=4, GAP=3, DEPTH=4.
module tb_keypad_emulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push = 1'b0;
  logic [3:0] push_key = 4'h0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] col = 4'hF;
  logic [3:0] row;
  logic       busy, done, full, empty, overflow;

  int tests = 0;
  int fails = 0;
  int done_seen = 0;

  keypad_emulator #(.DEPTH(4), .HOLD_CYCLES(4), .GAP_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .push(push), .push_key(push_key), .start(start),
    .clear(clear), .col(col), .row(row), .busy(busy), .done(done),
    .full(full), .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called with the DUT in LOAD; leaves it in the state after the key's last gap cycle.
  // mode 1 pushes lk during LOAD, mode 2 pushes lk in the first PRESS cycle.
  task automatic play_key(input string tag, input logic [3:0] exp_row, input logic exp_empty,
                          input logic exp_full, input int mode, input logic [3:0] lk);
    chk({tag, "_load_row"}, row, 4'hF);
    chk({tag, "_load_busy"}, busy, 1'b1);
    if (mode == 1) begin push = 1'b1; push_key = lk; end
    tick();
    push = 1'b0;
    chk({tag, "_empty"}, empty, exp_empty);
    chk({tag, "_full"}, full, exp_full);
    if (mode == 2) begin push = 1'b1; push_key = lk; end
    for (int j = 0; j < 4; j++) begin
      chk({tag, "_press_row"}, row, exp_row);
      tick();
      push = 1'b0;
    end
    for (int j = 0; j < 3; j++) begin
      chk({tag, "_gap_row"}, row, 4'hF);
      chk({tag, "_gap_done"}, done, 1'b0);
      tick();
    end
  endtask

  initial begin
    // Reset values
    tick(); tick();
    rst = 1'b0;
    chk("rst_row", row, 4'hF);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_ovf", overflow, 1'b0);

    // 1: single key 0110, column 1 goes low one cycle into the press
    push = 1'b1; push_key = 4'b0110; tick(); push = 1'b0;
    chk("t1_empty", empty, 1'b0);
    col = 4'b1110; start = 1'b1; tick(); start = 1'b0;
    chk("t1_load_busy", busy, 1'b1);
    chk("t1_load_row", row, 4'hF);
    tick();
    chk("t1_wrong_col_row", row, 4'hF);
    col = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_press_row", row, 4'b1011);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_gap_row", row, 4'hF);
      chk("t1_gap_done", done, 1'b0);
    end
    tick();
    chk("t1_done", done, 1'b1);
    chk("t1_busy_end", busy, 1'b0);
    tick();
    chk("t1_done_low", done, 1'b0);
    chk("t1_done_seen", done_seen, 1);

    // 2: four keys in order
    col = 4'h0;
    for (int k = 0; k < 4; k++) begin
      push = 1'b1; push_key = 4'(k * 5); tick();
    end
    push = 1'b0;
    chk("t2_full", full, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    play_key("t2_k0", 4'b1110, 1'b0, 1'b0, 0, 4'h0);
    play_key("t2_k5", 4'b1101, 1'b0, 1'b0, 0, 4'h0);
    play_key("t2_k10", 4'b1011, 1'b0, 1'b0, 0, 4'h0);
    play_key("t2_k15", 4'b0111, 1'b1, 1'b0, 0, 4'h0);
    chk("t2_done", done, 1'b1);
    chk("t2_busy_end", busy, 1'b0);
    tick();
    chk("t2_done_seen", done_seen, 2);

    // 3: overflow, and a push into a full FIFO alongside the LOAD pop
    push = 1'b1; push_key = 4'd1; tick();
    push_key = 4'd2; tick();
    push_key = 4'd3; tick();
    push_key = 4'd4; tick();
    chk("t3_full4", full, 1'b1);
    chk("t3_ovf4", overflow, 1'b0);
    push_key = 4'd9; tick(); push = 1'b0;
    chk("t3_ovf5", overflow, 1'b1);
    chk("t3_full5", full, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    play_key("t3_k1", 4'b1101, 1'b0, 1'b1, 1, 4'd7);
    play_key("t3_k2", 4'b1011, 1'b0, 1'b0, 0, 4'h0);
    play_key("t3_k3", 4'b0111, 1'b0, 1'b0, 0, 4'h0);
    play_key("t3_k4", 4'b1110, 1'b0, 1'b0, 0, 4'h0);
    play_key("t3_k7", 4'b0111, 1'b1, 1'b0, 0, 4'h0);
    chk("t3_done", done, 1'b1);
    tick();
    chk("t3_done_seen", done_seen, 3);

    // 4: clear (with push and start) in the 2nd press cycle of key 2 of 3
    push = 1'b1; push_key = 4'd1; tick();
    push_key = 4'd2; tick();
    push_key = 4'd3; tick(); push = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    play_key("t4_k1", 4'b1101, 1'b0, 1'b0, 0, 4'h0);
    chk("t4_k2_load_row", row, 4'hF);
    tick();
    chk("t4_k2_press1", row, 4'b1011);
    tick();
    chk("t4_k2_press2", row, 4'b1011);
    clear = 1'b1; push = 1'b1; push_key = 4'd5; start = 1'b1; tick();
    clear = 1'b0; push = 1'b0; start = 1'b0;
    chk("t4_clr_row", row, 4'hF);
    chk("t4_clr_busy", busy, 1'b0);
    chk("t4_clr_empty", empty, 1'b1);
    chk("t4_clr_done", done, 1'b0);
    chk("t4_clr_ovf", overflow, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    chk("t4_start_busy", busy, 1'b0);
    tick();
    chk("t4_start_busy2", busy, 1'b0);
    chk("t4_done_seen", done_seen, 3);

    // 5: reset mid-gap with overflow set
    push = 1'b1; push_key = 4'd5; tick();
    push_key = 4'd6; tick(); push = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("t5_gap_row", row, 4'hF);
    chk("t5_gap_busy", busy, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_row", row, 4'hF);
    chk("t5_busy", busy, 1'b0);
    chk("t5_done", done, 1'b0);
    chk("t5_full", full, 1'b0);
    chk("t5_empty", empty, 1'b1);
    chk("t5_ovf", overflow, 1'b0);
    tick();
    chk("t5_busy_after", busy, 1'b0);

    // 6: start while empty, then a key appended during the last key's press
    start = 1'b1; tick(); start = 1'b0;
    chk("t6_empty_start_busy", busy, 1'b0);
    tick();
    chk("t6_empty_start_busy2", busy, 1'b0);
    push = 1'b1; push_key = 4'd2; tick(); push = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    play_key("t6_k2", 4'b1011, 1'b1, 1'b0, 2, 4'd8);
    play_key("t6_k8", 4'b1110, 1'b1, 1'b0, 0, 4'h0);
    chk("t6_done", done, 1'b1);
    chk("t6_busy_end", busy, 1'b0);
    tick();
    chk("t6_done_low", done, 1'b0);
    chk("t6_done_seen", done_seen, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Responder side of the 4x4 matrix keypad interface. Models a physical keypad being typed on by a user, so the lock can be exercised in simulation and hardware-in-loop without a human.
- Queues key positions pushed by a host (bench or test sequencer).
- Replays them as timed press/release events by driving the row lines in answer to the scanner's column drive.
- Sits between a test host and the keypad scan logic inside the SSD/keypad subsystem, replacing the physical keypad.

Parameters:
- DEPTH, 8, key FIFO entries (power of 2, ≥2).
- HOLD_CYCLES, 2_500_000, clk cycles a key stays pressed (50 ms at 50 MHz); ≥1.
- GAP_CYCLES, 2_500_000, clk cycles of release between keys; ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- push  in  1  enqueue push_key this cycle.
- push_key  in  4  key position: [3:2] column index, [1:0] row index.
- start  in  1  single-cycle pulse; begin replaying the queue.
- clear  in  1  abort the replay and flush the FIFO.
- col  in  4  column drive from the scanner; active-low, the driven column is 0.
- row  out  4  row lines to the scanner; active-low, 4'hF means no key.
- busy  out  1  replay in progress.
- done  out  1  one-cycle pulse when the last key's gap ends.
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- overflow  out  1  sticky; a push was dropped while full.

Behaviour:
- Reset (rst=1 at a clk edge) values:
  - row=4'hF, busy=0, done=0, full=0, empty=1, overflow=0.
  - FIFO pointers and count = 0, FSM=IDLE, all counters 0.
  - Reset mid-replay aborts immediately with the same values.
- FIFO:
  - Circular, count width $clog2(DEPTH)+1.
  - push while !full: write at wr_ptr, wr_ptr wraps at DEPTH.
  - push while full and no pop this cycle: dropped, overflow<=1.
  - Push and pop in the same cycle: both take effect and count is unchanged, including when full.
  - full/empty are registered and consistent with count in the same cycle.
- FSM states: IDLE, LOAD, PRESS, GAP.
  - IDLE: busy=0. On start with !empty go to LOAD. start while empty is ignored and done is not pulsed. start while busy is ignored.
  - LOAD (1 cycle): pop the head into cur_key, clear the counter, go to PRESS. busy=1 from this state until return to IDLE.
  - PRESS: count HOLD_CYCLES cycles, then go to GAP with the counter cleared.
  - GAP: count GAP_CYCLES cycles. At the end, go to LOAD if !empty; otherwise go to IDLE and pulse done for 1 cycle.
  - Keys pushed during replay are appended and played in the same run.
- clear:
  - Any state goes to IDLE and the FIFO is flushed.
  - row=4'hF next cycle; no done pulse; overflow is kept.
  - clear has priority over start and push in the same cycle.
- Row drive (registered, 1-cycle latency from col):
  - In PRESS with col[cur_key[3:2]]==0: row <= ~(4'b1 << cur_key[1:0]).
  - Otherwise row <= 4'hF.
  - Other column bits are ignored, so multiple low columns are tolerated.
  - row is 4'hF in IDLE, LOAD, and GAP.
- Timing summary:
  - Press interval is exactly HOLD_CYCLES cycles, starting the cycle after LOAD.
  - Release interval is exactly GAP_CYCLES cycles.
  - Per-key period is HOLD_CYCLES+GAP_CYCLES+1.

Test Plan (HOLD_CYCLES=4, GAP_CYCLES=3, DEPTH=4):
1. Reset, push key 4'b0110, start, col held 4'b1110 then 4'b1101.
   - PRESS lasts 4 cycles.
   - With col=4'b1101 (column 1 low): row=4'b1011 one cycle after col changes.
   - With col=4'b1110: row=4'hF.
   - done pulses once 4+3+1 cycles after start+1; busy then goes low.
2. Push keys 0,5,10,15, then start.
   - Keys are replayed in order with 3-cycle row=F gaps.
   - empty=1 after the 4th LOAD.
   - Exactly one done pulse.
3. Push 5 keys into DEPTH=4 with no pops.
   - full=1 after the 4th push.
   - overflow=1 after the 5th push; the 5th key is never replayed.
   - Push while full in the same cycle as a LOAD pop is accepted.
4. Assert clear in the 2nd PRESS cycle of key 2 of 3.
   - Next cycle: row=F, busy=0, empty=1, no done pulse.
   - A later start is ignored.
5. Assert rst mid-GAP with overflow=1.
   - All outputs return to reset values, including overflow=0.
6. Pulse start with an empty FIFO.
   - busy stays 0, no done pulse.
   - Push during PRESS of the last key: the new key is appended and played before done.
